// File: rtl/sarlock_seq_lock.sv
// SARLock-style logic lock with a serially loaded key.
// Outputs stay corrupted until a full-width key is committed; a wrong key then flips exactly one input pattern.
module sarlock_seq_lock #(
    parameter int IN_W = 5,
    parameter int OUT_W = 2,
    parameter logic [IN_W-1:0] SECRET_KEY = 5'b10110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sin,
    input  logic             key_shift,
    input  logic             key_commit,
    input  logic [IN_W-1:0]  data_in,
    input  logic [OUT_W-1:0] func_in,
    output logic [OUT_W-1:0] data_out,
    output logic             armed,
    output logic             commit_err
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        UNKEYED,
        SHIFTING,
        ARMED
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   key_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              flip;

    // Only the one pattern equal to a wrong key is disturbed; the correct key never flips anything.
    assign flip = (data_in == key_reg) && (key_reg != SECRET_KEY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNKEYED;
            key_reg    <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            armed      <= 1'b0;
            commit_err <= 1'b0;
        end else begin
            commit_err <= 1'b0;
            if (state == ARMED) begin
                data_out <= func_in ^ {OUT_W{flip}};
            end else begin
                data_out <= ~func_in;
            end

            // A shift always wins over a simultaneous commit, which is then reported as rejected.
            if (key_shift) begin
                key_reg <= {key_sin, key_reg[IN_W-1:1]};
                armed   <= 1'b0;
                if (state != SHIFTING) begin
                    state   <= SHIFTING;
                    bit_cnt <= CNT_ONE;
                end else if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + CNT_ONE;
                end
                if (key_commit) begin
                    commit_err <= 1'b1;
                end
            end else if (key_commit) begin
                if ((state == SHIFTING) && (bit_cnt == CNT_MAX)) begin
                    state <= ARMED;
                    armed <= 1'b1;
                end else begin
                    commit_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sarlock_seq_lock.sv
// Bench for sarlock_seq_lock: vector tables and sweeps feed a scoreboard queue of expected outputs.
module tb_sarlock_seq_lock;

    logic       clk;
    logic       rst;
    logic       key_sin;
    logic       key_shift;
    logic       key_commit;
    logic [4:0] data_in;
    logic [1:0] func_in;
    logic [1:0] data_out;
    logic       armed;
    logic       commit_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       sin;
        logic       shift;
        logic       commit;
        logic [4:0] din;
        logic [1:0] fin;
        logic [1:0] dout;
        logic       arm;
        logic       err;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] dout;
        logic       arm;
        logic       err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    sarlock_seq_lock #(
        .IN_W(5),
        .OUT_W(2),
        .SECRET_KEY(5'b10110)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_sin(key_sin),
        .key_shift(key_shift),
        .key_commit(key_commit),
        .data_in(data_in),
        .func_in(func_in),
        .data_out(data_out),
        .armed(armed),
        .commit_err(commit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic sin, logic shift, logic commit,
                                logic [4:0] din, logic [1:0] fin,
                                logic [1:0] dout, logic arm, logic err);
        vec_t v;
        v.name = name; v.sin = sin; v.shift = shift; v.commit = commit;
        v.din = din; v.fin = fin; v.dout = dout; v.arm = arm; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, ".data_out"}, {30'd0, data_out}, {30'd0, e.dout});
            check({e.name, ".armed"}, {31'd0, armed}, {31'd0, e.arm});
            check({e.name, ".commit_err"}, {31'd0, commit_err}, {31'd0, e.err});
        end
    endtask

    // Drive one cycle of inputs, queue what the next edge must produce, then compare after that edge.
    task automatic applyStimulus(vec_t v);
        exp_t e;
        key_sin    = v.sin;
        key_shift  = v.shift;
        key_commit = v.commit;
        data_in    = v.din;
        func_in    = v.fin;
        e.name = v.name; e.dout = v.dout; e.arm = v.arm; e.err = v.err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int end_a;
        int end_b;
        logic [4:0] key_bits;

        // Table A: from reset, reject an early commit, load the correct key and arm.
        tbl.push_back(mk("idle_unkeyed",   0, 0, 0, 5'd0, 2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("commit_unkeyed", 0, 0, 1, 5'd0, 2'b01, 2'b10, 0, 1));
        key_bits = 5'b10110;
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("shift_good", key_bits[i], 1, 0, 5'd0, 2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("commit_good", 0, 0, 1, 5'd0, 2'b01, 2'b10, 1, 0));
        end_a = tbl.size();

        // Table B: re-key from ARMED to a wrong key 5'b00011 through short-commit and shift+commit corners.
        tbl.push_back(mk("shift_from_armed", 1, 1, 0, 5'b10110, 2'b01, 2'b01, 0, 0));
        tbl.push_back(mk("after_rearm",      1, 1, 0, 5'b10110, 2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("shift3",           0, 1, 0, 5'd0,     2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("commit_short",     0, 0, 1, 5'd0,     2'b01, 2'b10, 0, 1));
        tbl.push_back(mk("err_clears",       0, 0, 0, 5'd0,     2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("shift4",           0, 1, 0, 5'd0,     2'b01, 2'b10, 0, 0));
        tbl.push_back(mk("shift_and_commit", 0, 1, 1, 5'd0,     2'b01, 2'b10, 0, 1));
        tbl.push_back(mk("commit_wrong_key", 0, 0, 1, 5'd0,     2'b10, 2'b01, 1, 0));
        end_b = tbl.size();

        // Table C: after a reset the key is gone; 4 bits are not enough, the 5th makes 5'b01101.
        tbl.push_back(mk("first_after_rst", 0, 0, 0, 5'd0, 2'b11, 2'b00, 0, 0));
        tbl.push_back(mk("commit_after_rst", 0, 0, 1, 5'd0, 2'b11, 2'b00, 0, 1));
        key_bits = 5'b01101;
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("reload", key_bits[i], 1, 0, 5'd0, 2'b10, 2'b01, 0, 0));
        tbl.push_back(mk("commit_partial", 0, 0, 1, 5'd0, 2'b10, 2'b01, 0, 1));
        tbl.push_back(mk("reload_last", key_bits[4], 1, 0, 5'd0, 2'b10, 2'b01, 0, 0));
        tbl.push_back(mk("commit_reload", 0, 0, 1, 5'd0, 2'b10, 2'b01, 1, 0));
        tbl.push_back(mk("hit_wrong_key", 0, 0, 0, 5'b01101, 2'b10, 2'b01, 1, 0));
        tbl.push_back(mk("miss_wrong_key", 0, 0, 0, 5'b01100, 2'b10, 2'b10, 1, 0));

        rst = 1'b1;
        key_sin = 0; key_shift = 0; key_commit = 0; data_in = 5'd0; func_in = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check("reset.data_out", {30'd0, data_out}, 32'd0);
        check("reset.armed", {31'd0, armed}, 32'd0);
        check("reset.commit_err", {31'd0, commit_err}, 32'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < end_a; i++) applyStimulus(tbl[i]);
        for (int d = 0; d < 32; d++)
            applyStimulus(mk("sweep_good", 0, 0, 0, 5'(d), 2'b01, 2'b01, 1, 0));

        for (int i = end_a; i < end_b; i++) applyStimulus(tbl[i]);
        for (int d = 0; d < 32; d++)
            applyStimulus(mk("sweep_wrong", 0, 0, 0, 5'(d), 2'b10,
                             (d == 3) ? 2'b01 : 2'b10, 1, 0));

        // Asynchronous reset between edges while ARMED must clear outputs before any clock.
        #2 rst = 1'b1;
        #1;
        check("async_rst.data_out", {30'd0, data_out}, 32'd0);
        check("async_rst.armed", {31'd0, armed}, 32'd0);
        check("async_rst.commit_err", {31'd0, commit_err}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        for (int i = end_b; i < tbl.size(); i++) applyStimulus(tbl[i]);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
